// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM encoding and small-sigma helpers for the
// message schedule and compression blocks.
package sha256_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NUM_IN  = 16;
  localparam int unsigned NUM_OUT = 64;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } sched_state_e;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/cla_adder32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// No carry-in or carry-out; the sum wraps modulo 2^32.
module cla_adder32
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum
);

  localparam int unsigned GRP_W   = 4;
  localparam int unsigned NUM_GRP = WORD_W / GRP_W;

  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] p;
  logic [WORD_W-1:0] c;
  logic [GRP_W-1:0]  gg;
  logic [GRP_W-1:0]  pp;
  logic              cin;

  assign g = a & b;
  assign p = a ^ b;

  // Per-group lookahead equations; group carry-out feeds the next group.
  always_comb begin
    c   = '0;
    gg  = '0;
    pp  = '0;
    cin = 1'b0;
    for (int k = 0; k < int'(NUM_GRP); k++) begin
      gg = g[k*GRP_W +: GRP_W];
      pp = p[k*GRP_W +: GRP_W];
      c[k*GRP_W + 0] = cin;
      c[k*GRP_W + 1] = gg[0] | (pp[0] & cin);
      c[k*GRP_W + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
      c[k*GRP_W + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & cin);
      cin = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
          | (pp[3] & pp[2] & pp[1] & gg[0])
          | (pp[3] & pp[2] & pp[1] & pp[0] & cin);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, emits W[0..63] from a rolling
// 16-word window, overwriting W[t-16] with W[t] as each word is accepted.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [CNT_W-1:0]  out_index,
  output logic              busy
);

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] win [NUM_IN];

  logic              win_we;
  logic [IDX_W-1:0]  win_addr;
  logic [WORD_W-1:0] win_wdata;

  logic [IDX_W-1:0]  slot;
  logic              expand;
  logic              emit;
  logic [WORD_W-1:0] s0, s1;
  logic [WORD_W-1:0] sum_a, sum_b, w_exp;

  assign slot   = cnt_q[IDX_W-1:0];
  assign expand = (cnt_q >= CNT_W'(NUM_IN));
  assign emit   = (state_q == ST_EMIT);

  // Window slot arithmetic wraps modulo 16; slot itself still holds W[t-16].
  assign s1 = small_sigma1(win[slot - IDX_W'(2)]);
  assign s0 = small_sigma0(win[slot - IDX_W'(15)]);

  cla_adder32 u_add_a (.a(s1),    .b(win[slot - IDX_W'(7)]), .sum(sum_a));
  cla_adder32 u_add_b (.a(sum_a), .b(s0),                    .sum(sum_b));
  cla_adder32 u_add_c (.a(sum_b), .b(win[slot]),             .sum(w_exp));

  // Status decodes of the state register; word/index follow the window.
  assign in_ready  = ~emit;
  assign out_valid = emit;
  assign busy      = emit;
  assign out_index = emit ? cnt_q : '0;
  assign out_word  = emit ? (expand ? w_exp : win[slot]) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Window storage is not reset; its contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (win_we) begin
      win[win_addr] <= win_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_we    = 1'b0;
    win_addr  = slot;
    win_wdata = in_word;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          win_we = 1'b1;
          if (cnt_q == CNT_W'(NUM_IN - 1)) begin
            state_d = ST_EMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          win_we    = expand;
          win_wdata = w_exp;
          if (cnt_q == CNT_W'(NUM_OUT - 1)) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized self-checking bench for sha256_msg_schedule against a
// plain-arithmetic SHA-256 schedule model.
module tb_sha256_msg_schedule;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_index;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];

  sha256_msg_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_index(out_index),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule built directly from the SHA-256 recurrence.
  task automatic build_model();
    logic [31:0] a, b;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = msg[t];
      else begin
        a = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
        b = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
        exp_w[t] = a + exp_w[t-7] + b + exp_w[t-16];
      end
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    build_model();
  endtask

  task automatic set_zero();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    build_model();
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    build_model();
  endtask

  // Called at posedge+1. Leaves time at posedge+1 after the 16th handshake.
  task automatic send_block(input bit stalls);
    for (int i = 0; i < 16; i++) begin
      if (stalls) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_word  = $urandom;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_word  = msg[i];
      check("load_in_ready", 32'(in_ready), 32'd1);
      check("load_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("first_out_valid", 32'(out_valid), 32'd1);
    check("first_busy", 32'(busy), 32'd1);
    check("first_index", 32'(out_index), 32'd0);
  endtask

  // rdy_mode 0: out_ready high except the bp window; 1: random 50%.
  task automatic recv_block(input int rdy_mode, input int bp_t, input int stop_t,
                            input bit poke, input bit kat);
    int t = 0;
    int cyc = 0;
    int bp_cnt = 0;
    bit bp_on;
    while (t < stop_t && cyc < 2000) begin
      bp_on = (t == bp_t) && (bp_cnt < 5);
      if (bp_on) begin
        out_ready = 1'b0;
        bp_cnt++;
      end else begin
        out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (poke) begin
        in_valid = 1'($urandom_range(0, 1));
        in_word  = $urandom;
        check("emit_in_ready", 32'(in_ready), 32'd0);
      end
      check("emit_busy", 32'(busy), 32'd1);
      if (rdy_mode == 0) check("emit_valid", 32'(out_valid), 32'd1);
      if (bp_on) begin
        check("bp_word", out_word, exp_w[t]);
        check("bp_index", 32'(out_index), 32'(t));
      end
      if (out_valid && out_ready) begin
        check("word", out_word, exp_w[t]);
        check("index", 32'(out_index), 32'(t));
        if (kat) begin
          if (t == 16) check("abc_w16", out_word, 32'h61626380);
          if (t == 17) check("abc_w17", out_word, 32'h000F0000);
          if (t == 18) check("abc_w18", out_word, 32'h7DA86405);
          if (t == 63) check("abc_w63", out_word, 32'h12B1EDEB);
        end
        t++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (t < stop_t) check("recv_timeout", 32'(t), 32'(stop_t));
    if (stop_t == 64) begin
      check("done_in_ready", 32'(in_ready), 32'd1);
      check("done_out_valid", 32'(out_valid), 32'd0);
      check("done_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_word", out_word, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc" block, consumer always ready
    set_abc();
    send_block(1'b0);
    recv_block(0, -1, 64, 1'b0, 1'b1);

    // all-zero block, 64 consecutive words
    set_zero();
    send_block(1'b0);
    recv_block(0, -1, 64, 1'b0, 1'b0);

    // "abc" with a 5-cycle stall at t=20
    set_abc();
    send_block(1'b0);
    recv_block(0, 20, 64, 1'b0, 1'b1);

    // "abc" with input gaps and in_valid pulses during emit
    set_abc();
    send_block(1'b1);
    recv_block(0, -1, 64, 1'b1, 1'b1);

    // reset in the middle of emission
    set_abc();
    send_block(1'b0);
    recv_block(0, -1, 30, 1'b0, 1'b0);
    check("pre_rst_index", 32'(out_index), 32'd30);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_index", 32'(out_index), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_block(1'b0);
    recv_block(0, -1, 64, 1'b0, 1'b1);

    // two back-to-back random blocks, random consumer
    for (int blk = 0; blk < 2; blk++) begin
      set_random();
      send_block(1'b1);
      recv_block(1, -1, 64, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
